flashing_light_core: RTL and testbench

LED pattern engine sitting directly downstream of the flashing_light AXI4-Lite register file (slave registers 0..3). Consumes the four 32-bit software registers, generates a timed LED frame sequence (static, blink, rotate, bounce), applies 8-bit PWM dimming and drives the board LEDs. Also returns a status word for software readback.

---
 rtl/flashing_light_pkg.sv | 20 ++
 rtl/flashing_light_pwm.sv | 15 +
 rtl/flashing_light_core.sv | 109 ++++++++++
 tb/tb_flashing_light_core.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/flashing_light_pkg.sv
// flashing_light_pkg: shared types and register/status bit positions for the LED pattern engine
package flashing_light_pkg;
  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
  localparam logic DIR_LEFT    = 1'b0;
  localparam int   CTRL_EN     = 0;
  localparam int   CTRL_MODE   = 1;
  localparam int   CTRL_BYPASS = 3;
  localparam int   STAT_RUN    = 16;
  localparam int   STAT_DIR    = 17;
  localparam int   STAT_FRAME  = 24;
endpackage

// File: rtl/flashing_light_pwm.sv
// flashing_light_pwm: free-running 8-bit PWM counter and duty comparator
module flashing_light_pwm (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] duty_i,
  input  logic       bypass_i,
  output logic       pwm_on_o
);
  logic [7:0] cnt_q, cnt_d;
  assign cnt_d    = cnt_q + 8'd1;
  assign pwm_on_o = bypass_i | (cnt_q < duty_i);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/flashing_light_core.sv
// flashing_light_core: timed LED frame sequencer (static/blink/rotate/bounce) with PWM dimming
module flashing_light_core
  import flashing_light_pkg::*;
#(
  parameter int LED_WIDTH          = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] period_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] pattern_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] duty_reg,
  input  logic                          cfg_wr,
  output logic [LED_WIDTH-1:0]          led_o,
  output logic                          tick_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] status_o
);
  state_e                        state_q, state_d;
  mode_e                         mode;
  logic [C_S_AXI_DATA_WIDTH-1:0] presc_q, presc_d, last;
  logic [15:0]                   step_q, step_d;
  logic                          dir_q, dir_d, tick_q, tick_d;
  logic [LED_WIDTH-1:0]          frame_q, frame_d, led_q, led_d;
  logic [LED_WIDTH-1:0]          pattern, bounce_nxt, frame_step, frame_load;
  logic [7:0]                    frame8;
  logic                          enable, load, step_en, pwm_on, unused_bits;
  assign enable      = ctrl_reg[CTRL_EN];
  assign mode        = mode_e'(ctrl_reg[CTRL_MODE +: 2]);
  assign pattern     = pattern_reg[LED_WIDTH-1:0];
  assign last        = (period_reg == '0) ? '0 : period_reg - 1'b1;
  assign unused_bits = ^{ctrl_reg[C_S_AXI_DATA_WIDTH-1:4], pattern_reg[C_S_AXI_DATA_WIDTH-1:LED_WIDTH],
                         duty_reg[C_S_AXI_DATA_WIDTH-1:8]};
  flashing_light_pwm u_pwm (
    .clk_i   (ACLK),
    .rst_ni  (ARESETN),
    .duty_i  (duty_reg[7:0]),
    .bypass_i(ctrl_reg[CTRL_BYPASS]),
    .pwm_on_o(pwm_on)
  );
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) state_q <= ST_IDLE;
    else state_q <= state_d;
  always_comb state_d = enable ? ST_RUN : ST_IDLE;
  // Reload beats a coincident tick, so a config write never counts a step.
  always_comb begin
    load    = enable & ((state_q == ST_IDLE) | cfg_wr);
    step_en = enable & (state_q == ST_RUN) & ~cfg_wr & (presc_q >= last);
  end
  // The bounce direction flips on the very edge the lit bit lands on an end.
  assign bounce_nxt = dir_q ? frame_q >> 1 : frame_q << 1;
  assign frame_step = (mode == MODE_STATIC) ? frame_q :
                      (mode == MODE_BLINK)  ? ((|frame_q) ? '0 : pattern) :
                      (mode == MODE_ROTATE) ? {frame_q[LED_WIDTH-2:0], frame_q[LED_WIDTH-1]} :
                                              bounce_nxt;
  assign frame_load = (mode == MODE_BOUNCE) ? {{(LED_WIDTH-1){1'b0}}, 1'b1} : pattern;
  always_comb begin
    frame_d = frame_q;
    dir_d   = dir_q;
    step_d  = step_q;
    presc_d = presc_q + 1'b1;
    if (!enable) begin
      frame_d = '0;
      dir_d   = DIR_LEFT;
      step_d  = '0;
      presc_d = '0;
    end else if (load) begin
      frame_d = frame_load;
      dir_d   = DIR_LEFT;
      step_d  = '0;
      presc_d = '0;
    end else if (step_en) begin
      frame_d = frame_step;
      dir_d   = (mode != MODE_BOUNCE) ? dir_q :
                dir_q ? ~bounce_nxt[0] : bounce_nxt[LED_WIDTH-1];
      step_d  = step_q + 16'd1;
      presc_d = '0;
    end
  end
  assign tick_d = step_en;
  assign led_d  = frame_q & {LED_WIDTH{pwm_on}};
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      presc_q <= '0;
      step_q  <= '0;
      dir_q   <= DIR_LEFT;
      frame_q <= '0;
      led_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      frame_q <= frame_d;
      led_q   <= led_d;
      tick_q  <= tick_d;
    end
  always_comb begin
    frame8                   = '0;
    frame8[LED_WIDTH-1:0]    = frame_q;
    status_o                 = '0;
    status_o[15:0]           = step_q;
    status_o[STAT_RUN]       = (state_q == ST_RUN);
    status_o[STAT_DIR]       = dir_q;
    status_o[STAT_FRAME +: 8] = frame8;
  end
  assign led_o  = led_q;
  assign tick_o = tick_q;
endmodule

// File: tb/tb_flashing_light_core.sv
// tb_flashing_light_core: random and directed stimulus against a closed-form pattern model,
// expected outputs queued per edge and compared by an independent monitor.
module tb_flashing_light_core;
  localparam int W = 4;
  logic ACLK = 1'b0, ARESETN = 1'b0, cfg_wr = 1'b0;
  logic [31:0] ctrl_reg = '0, period_reg = '0, pattern_reg = '0, duty_reg = '0;
  logic [W-1:0] led_o;
  logic tick_o;
  logic [31:0] status_o;
  int checks = 0, errors = 0;
  typedef struct {
    logic [W-1:0] led;
    logic         tick;
    logic [31:0]  status;
  } exp_t;
  exp_t q[$];
  bit run_m = 0;
  int k_m = 0, presc_m = 0, pwm_m = 0, mode_m = 0;
  logic [W-1:0] pat_m = '0;

  flashing_light_core #(.LED_WIDTH(W), .C_S_AXI_DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .ctrl_reg(ctrl_reg), .period_reg(period_reg),
    .pattern_reg(pattern_reg), .duty_reg(duty_reg), .cfg_wr(cfg_wr),
    .led_o(led_o), .tick_o(tick_o), .status_o(status_o)
  );

  always #5 ACLK = ~ACLK;

  // Frame after k ticks since the last load, straight from the mode rules.
  function automatic logic [W-1:0] frame_of(bit r, int m, int k, logic [W-1:0] p);
    logic [2*W-1:0] dbl;
    int pos;
    if (!r) return '0;
    pos = k % (2 * (W - 1));
    if (m == 0) return p;
    if (m == 1) return (k % 2 == 1) ? '0 : p;
    if (m == 2) begin
      dbl = {p, p} << (k % W);
      return dbl[2*W-1:W];
    end
    return {{(W-1){1'b0}}, 1'b1} << ((pos <= W - 1) ? pos : 2 * (W - 1) - pos);
  endfunction

  function automatic bit dir_of(bit r, int m, int k);
    return r && m == 3 && (k % (2 * (W - 1))) >= W - 1;
  endfunction

  task automatic model_step();
    exp_t e;
    logic [7:0] f8;
    bit on;
    int p;
    if (!ARESETN) begin
      run_m = 0; k_m = 0; presc_m = 0; pwm_m = 0;
      q.delete();
      return;
    end
    on = ctrl_reg[3] || (pwm_m < int'(duty_reg[7:0]));
    e.led = on ? frame_of(run_m, mode_m, k_m, pat_m) : '0;
    e.tick = 1'b0;
    p = (period_reg == 0) ? 1 : int'(period_reg);
    if (!ctrl_reg[0]) begin
      run_m = 0; k_m = 0; presc_m = 0;
    end else if (!run_m || cfg_wr) begin
      run_m = 1; k_m = 0; presc_m = 0;
      mode_m = int'(ctrl_reg[2:1]);
      pat_m = pattern_reg[W-1:0];
    end else if (presc_m >= p - 1) begin
      presc_m = 0; k_m++; e.tick = 1'b1;
    end else presc_m++;
    pwm_m = (pwm_m + 1) % 256;
    f8 = 8'(frame_of(run_m, mode_m, k_m, pat_m));
    e.status = {f8, 6'b0, dir_of(run_m, mode_m, k_m), run_m, k_m[15:0]};
    q.push_back(e);
  endtask

  initial forever begin
    @(posedge ACLK or negedge ARESETN);
    model_step();
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (ARESETN && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (led_o !== e.led || tick_o !== e.tick || status_o !== e.status) begin
          errors++;
          $display("FAIL scoreboard t=%0t: led=%h tick=%b status=%h, required led=%h tick=%b status=%h",
                   $time, led_o, tick_o, status_o, e.led, e.tick, e.status);
        end
      end
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick_n(int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic wr(logic [31:0] c, logic [31:0] p, logic [31:0] pt, logic [31:0] d);
    ctrl_reg = c; period_reg = p; pattern_reg = pt; duty_reg = d;
    cfg_wr = 1'b1;
    tick_n(1);
    cfg_wr = 1'b0;
  endtask

  initial begin
    int cnt, n, r;
    #12;
    chk("reset_led", 64'(led_o), 0);
    chk("reset_tick", 64'(tick_o), 0);
    chk("reset_status", 64'(status_o), 0);
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    tick_n(1000);
    chk("idle_status", 64'(status_o), 0);
    // STATIC with bypass, period 10
    wr(32'h9, 10, 32'h5, 0);
    tick_n(1000);
    chk("static_status", 64'(status_o), 64'h0501_0064);
    chk("static_led", 64'(led_o), 64'h5);
    chk("static_tick", 64'(tick_o), 1);
    // ROTATE period 4, then reload mid-run
    wr(32'hD, 4, 32'h1, 0);
    tick_n(10);
    chk("rotate_status", 64'(status_o), 64'h0401_0002);
    wr(32'hD, 4, 32'h1, 0);
    chk("rotate_reload", 64'(status_o), 64'h0101_0000);
    tick_n(20);
    // BOUNCE period 1
    wr(32'hF, 1, 32'h0, 0);
    tick_n(3);
    chk("bounce_msb", 64'(status_o), 64'h0803_0003);
    tick_n(3);
    chk("bounce_lsb", 64'(status_o), 64'h0101_0006);
    tick_n(10);
    // BLINK with duty 64, then duty 0
    wr(32'h3, 512, 32'hF, 64);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      tick_n(1);
      if (led_o == 4'hF) cnt++;
    end
    chk("blink_duty64", 64'(cnt), 64);
    tick_n(1200);
    wr(32'h3, 512, 32'hF, 0);
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      tick_n(1);
      if (led_o != '0) cnt++;
    end
    chk("duty0_dark", 64'(cnt), 0);
    // period shrinks below the running prescaler without a reload
    wr(32'hD, 100, 32'h3, 0);
    tick_n(60);
    period_reg = 10;
    tick_n(1);
    chk("period_shrink_tick", 64'(tick_o), 1);
    tick_n(30);
    // async reset mid-run with period 0
    wr(32'hD, 0, 32'h1, 0);
    tick_n(20);
    #3;
    ARESETN = 1'b0;
    #1;
    chk("async_led", 64'(led_o), 0);
    chk("async_tick", 64'(tick_o), 0);
    chk("async_status", 64'(status_o), 0);
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    chk("release_idle", 64'(status_o), 0);
    tick_n(1);
    chk("release_entry", 64'(status_o), 64'h0101_0000);
    tick_n(1);
    chk("period0_tick", 64'(tick_o), 1);
    chk("period0_status", 64'(status_o), 64'h0201_0001);
    // randomized segments
    for (int s = 0; s < 60; s++) begin
      wr({$urandom} & 32'hFFFF_FFFE | 32'($urandom_range(0, 4) != 0), $urandom_range(0, 9), $urandom, $urandom);
      n = $urandom_range(5, 80);
      repeat (n) begin
        r = $urandom_range(0, 29);
        if (r == 0) begin
          cfg_wr = 1'b1;
          tick_n(1);
          cfg_wr = 1'b0;
        end else begin
          if (r == 1) period_reg = $urandom_range(0, 9);
          tick_n(1);
        end
      end
    end
    tick_n(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
